csr_regblock: RTL and testbench
===============================

Name: csr_regblock

Overview:
- Memory-mapped control/status register block for the SoC CSR space; PeakRDL-style CPU interface.
- Sits behind the SoC bus adapter: the adapter drives req/addr/data/bit-enables and uses rd_ack|wr_ack as its ready.
- Provides a fixed register map: ID, scratch, control, status, sticky interrupt status with enable, and an event counter.
- Single clock; accesses complete with zero wait states.

Parameters:
- ADDR_WIDTH, 5: CPU byte-address width; bits [1:0] are ignored.
- ID_VALUE, 32'h5747_0001: constant returned by the ID register.

Ports:
- clk  in  1  system clock
- arst_n  in  1  asynchronous active-low reset
- s_cpuif_req  in  1  access request; single-cycle qualifier
- s_cpuif_req_is_wr  in  1  1 = write, 0 = read
- s_cpuif_addr  in  ADDR_WIDTH  byte address
- s_cpuif_wr_data  in  32  write data
- s_cpuif_wr_biten  in  32  per-bit write enable
- s_cpuif_req_stall_wr  out  1  write stall; tied 0
- s_cpuif_req_stall_rd  out  1  read stall; tied 0
- s_cpuif_rd_ack  out  1  read complete
- s_cpuif_rd_err  out  1  read to unmapped address
- s_cpuif_rd_data  out  32  read data
- s_cpuif_wr_ack  out  1  write complete
- s_cpuif_wr_err  out  1  write to unmapped or read-only address
- ctrl_o  out  32  CTRL register value
- status_i  in  32  live hardware status
- irq_set_i  in  32  per-bit interrupt set pulses
- irq_o  out  1  OR of (IRQ_STATUS & IRQ_ENABLE)
- cnt_inc_i  in  1  event-counter increment strobe

Behaviour:
Register map (word index = addr[ADDR_WIDTH-1:2]):
- 0x00 ID: RO, reads ID_VALUE.
- 0x04 SCRATCH: RW, reset 0.
- 0x08 CTRL: RW, reset 0, drives ctrl_o.
- 0x0C STATUS: RO, returns status_i as sampled in the request cycle.
- 0x10 IRQ_STATUS: W1C, reset 0.
- 0x14 IRQ_ENABLE: RW, reset 0.
- 0x18 EVT_CNT: RW, reset 0. Increments by 1 on cnt_inc_i, wrapping 0xFFFFFFFF -> 0. A software write loads the bit-enabled value; write wins over increment in the same cycle.
- 0x1C: unmapped.

CPU interface:
- Acks are combinational in the request cycle: rd_ack = req & ~is_wr; wr_ack = req & is_wr.
- rd_data, rd_err and wr_err are also combinational and are valid only while the matching ack is high.
- rd_data is 0 when rd_ack is low and on unmapped reads.
- Register updates from writes take effect at the next rising clk edge.
- Writes apply per bit: new = (old & ~biten) | (wdata & biten). biten = 0 leaves the register unchanged but is still acked.
- Writes to ID, STATUS or unmapped addresses: acked, wr_err = 1, no state change.
- Reads from unmapped addresses: rd_err = 1, data 0.
- Reads have no side effects.
- Stall outputs are always 0. Back-to-back requests on consecutive cycles are accepted.

IRQ_STATUS rules:
- Per bit, next = (cur & ~(write & biten & wdata)) | irq_set_i.
- Hardware set wins over a simultaneous software clear.
- A read in the same cycle as a set returns the pre-set value.
- irq_o is combinational from the register outputs.

Reset:
- arst_n low asynchronously clears SCRATCH, CTRL, IRQ_STATUS, IRQ_ENABLE and EVT_CNT; ctrl_o = 0 and irq_o = 0.
- While in reset, acks still follow req; reads return reset values and writes are ignored.
- Reset release is synchronised externally.

Test Plan:
- After reset: read 0x00 -> rd_ack=1 same cycle, data 0x57470001. Reads of 0x04/0x08/0x10/0x14/0x18 return 0; ctrl_o=0, irq_o=0.
- Write 0x04 = 0xDEADBEEF with biten 0x0000FFFF over an old value of 0x12345678 -> reads back 0x1234BEEF. Write 0x08 = 0xA5 with full biten -> ctrl_o = 0x000000A5 from the next cycle.
- status_i = 0xCAFEF00D, read 0x0C -> 0xCAFEF00D. Write 0x0C -> wr_ack=1, wr_err=1; a following read is unchanged. Read 0x1C -> rd_err=1, data 0.
- Pulse irq_set_i = 0x5 with IRQ_ENABLE = 0x4 -> IRQ_STATUS = 0x5, irq_o=1. Write 0x4 to 0x10 -> IRQ_STATUS = 0x1, irq_o=0. Set bit0 and write-1-clear bit0 in the same cycle -> bit0 stays 1.
- Pulse cnt_inc_i 3 times -> EVT_CNT = 3. Write 0xFFFFFFFF then one increment -> 0. Write 5 together with cnt_inc_i -> 5.
- Assert arst_n low mid-sequence without a clock edge -> ctrl_o and irq_o go 0 immediately, and all RW registers read 0 after release.

Source files
------------

// File: rtl/csr_regblock.sv
// -----------------------------------------------------------------------------
// csr_regblock
//   Memory-mapped control/status register block with a PeakRDL-style CPU
//   interface. Zero wait states: acks, read data and error flags are
//   combinational in the request cycle. Register updates land on the next
//   rising clk edge.
//
//   Register map (word index = s_cpuif_addr[ADDR_WIDTH-1:2]):
//     0x00 ID          RO   ID_VALUE
//     0x04 SCRATCH     RW
//     0x08 CTRL        RW   drives ctrl_o
//     0x0C STATUS      RO   live status_i
//     0x10 IRQ_STATUS  W1C  set by irq_set_i
//     0x14 IRQ_ENABLE  RW
//     0x18 EVT_CNT     RW   increments on cnt_inc_i
//     others           unmapped (rd_err / wr_err)
//
// Ports:
//   clk, arst_n                      clock, async active-low reset
//   s_cpuif_req/req_is_wr/addr       CPU request qualifier, direction, byte address
//   s_cpuif_wr_data/wr_biten         write data and per-bit write enable
//   s_cpuif_req_stall_wr/rd          stall outputs, always 0
//   s_cpuif_rd_ack/rd_err/rd_data    read response (same cycle)
//   s_cpuif_wr_ack/wr_err            write response (same cycle)
//   ctrl_o                           CTRL register value
//   status_i                         live hardware status
//   irq_set_i                        per-bit interrupt set pulses
//   irq_o                            OR of enabled pending interrupts
//   cnt_inc_i                        event counter increment strobe
// -----------------------------------------------------------------------------
module csr_regblock #(
    parameter int          ADDR_WIDTH = 5,
    parameter logic [31:0] ID_VALUE   = 32'h5747_0001
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  s_cpuif_req,
    input  logic                  s_cpuif_req_is_wr,
    input  logic [ADDR_WIDTH-1:0] s_cpuif_addr,
    input  logic [31:0]           s_cpuif_wr_data,
    input  logic [31:0]           s_cpuif_wr_biten,
    output logic                  s_cpuif_req_stall_wr,
    output logic                  s_cpuif_req_stall_rd,
    output logic                  s_cpuif_rd_ack,
    output logic                  s_cpuif_rd_err,
    output logic [31:0]           s_cpuif_rd_data,
    output logic                  s_cpuif_wr_ack,
    output logic                  s_cpuif_wr_err,
    output logic [31:0]           ctrl_o,
    input  logic [31:0]           status_i,
    input  logic [31:0]           irq_set_i,
    output logic                  irq_o,
    input  logic                  cnt_inc_i
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    localparam logic [IDX_W-1:0] IDX_ID         = IDX_W'(3'd0);
    localparam logic [IDX_W-1:0] IDX_SCRATCH    = IDX_W'(3'd1);
    localparam logic [IDX_W-1:0] IDX_CTRL       = IDX_W'(3'd2);
    localparam logic [IDX_W-1:0] IDX_STATUS     = IDX_W'(3'd3);
    localparam logic [IDX_W-1:0] IDX_IRQ_STATUS = IDX_W'(3'd4);
    localparam logic [IDX_W-1:0] IDX_IRQ_ENABLE = IDX_W'(3'd5);
    localparam logic [IDX_W-1:0] IDX_EVT_CNT    = IDX_W'(3'd6);

    // Bit-enabled merge of write data into an existing register value.
    function automatic logic [31:0] merge_biten(
        input logic [31:0] old_v,
        input logic [31:0] wdata,
        input logic [31:0] biten
    );
        return (old_v & ~biten) | (wdata & biten);
    endfunction

    logic [31:0]      scratch_r;
    logic [31:0]      ctrl_r;
    logic [31:0]      irq_status_r;
    logic [31:0]      irq_enable_r;
    logic [31:0]      evt_cnt_r;

    logic [IDX_W-1:0] widx_s;
    logic             rd_ack_s;
    logic             wr_ack_s;
    logic [31:0]      rd_val_s;
    logic             mapped_s;
    logic             writable_s;
    logic             wr_hit_s;
    logic             unused_addr_s;

    // Byte-offset bits carry no meaning for a word-wide register file.
    assign unused_addr_s = ^s_cpuif_addr[1:0];

    assign widx_s   = s_cpuif_addr[ADDR_WIDTH-1:2];
    assign rd_ack_s = s_cpuif_req & ~s_cpuif_req_is_wr;
    assign wr_ack_s = s_cpuif_req &  s_cpuif_req_is_wr;
    assign wr_hit_s = wr_ack_s & writable_s;

    // Address decode: read mux plus mapped/writable classification.
    always_comb begin
        rd_val_s   = 32'h0000_0000;
        mapped_s   = 1'b0;
        writable_s = 1'b0;
        case (widx_s)
            IDX_ID: begin
                rd_val_s   = ID_VALUE;
                mapped_s   = 1'b1;
                writable_s = 1'b0;
            end
            IDX_SCRATCH: begin
                rd_val_s   = scratch_r;
                mapped_s   = 1'b1;
                writable_s = 1'b1;
            end
            IDX_CTRL: begin
                rd_val_s   = ctrl_r;
                mapped_s   = 1'b1;
                writable_s = 1'b1;
            end
            IDX_STATUS: begin
                rd_val_s   = status_i;
                mapped_s   = 1'b1;
                writable_s = 1'b0;
            end
            IDX_IRQ_STATUS: begin
                rd_val_s   = irq_status_r;
                mapped_s   = 1'b1;
                writable_s = 1'b1;
            end
            IDX_IRQ_ENABLE: begin
                rd_val_s   = irq_enable_r;
                mapped_s   = 1'b1;
                writable_s = 1'b1;
            end
            IDX_EVT_CNT: begin
                rd_val_s   = evt_cnt_r;
                mapped_s   = 1'b1;
                writable_s = 1'b1;
            end
            default: begin
                rd_val_s   = 32'h0000_0000;
                mapped_s   = 1'b0;
                writable_s = 1'b0;
            end
        endcase
    end

    assign s_cpuif_req_stall_wr = 1'b0;
    assign s_cpuif_req_stall_rd = 1'b0;
    assign s_cpuif_rd_ack       = rd_ack_s;
    assign s_cpuif_wr_ack       = wr_ack_s;
    assign s_cpuif_rd_data      = rd_ack_s ? rd_val_s : 32'h0000_0000;
    assign s_cpuif_rd_err       = rd_ack_s & ~mapped_s;
    assign s_cpuif_wr_err       = wr_ack_s & ~writable_s;

    assign ctrl_o = ctrl_r;
    assign irq_o  = |(irq_status_r & irq_enable_r);

    // SCRATCH register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            scratch_r <= 32'h0000_0000;
        end else if (wr_hit_s && (widx_s == IDX_SCRATCH)) begin
            scratch_r <= merge_biten(scratch_r, s_cpuif_wr_data, s_cpuif_wr_biten);
        end
    end

    // CTRL register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ctrl_r <= 32'h0000_0000;
        end else if (wr_hit_s && (widx_s == IDX_CTRL)) begin
            ctrl_r <= merge_biten(ctrl_r, s_cpuif_wr_data, s_cpuif_wr_biten);
        end
    end

    // IRQ_STATUS: software clears first, hardware set is OR'd in afterwards so
    // a set pulse always survives a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            irq_status_r <= 32'h0000_0000;
        end else if (wr_hit_s && (widx_s == IDX_IRQ_STATUS)) begin
            irq_status_r <= (irq_status_r & ~(s_cpuif_wr_biten & s_cpuif_wr_data)) | irq_set_i;
        end else begin
            irq_status_r <= irq_status_r | irq_set_i;
        end
    end

    // IRQ_ENABLE register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            irq_enable_r <= 32'h0000_0000;
        end else if (wr_hit_s && (widx_s == IDX_IRQ_ENABLE)) begin
            irq_enable_r <= merge_biten(irq_enable_r, s_cpuif_wr_data, s_cpuif_wr_biten);
        end
    end

    // EVT_CNT: a software write takes priority over a same-cycle increment.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            evt_cnt_r <= 32'h0000_0000;
        end else if (wr_hit_s && (widx_s == IDX_EVT_CNT)) begin
            evt_cnt_r <= merge_biten(evt_cnt_r, s_cpuif_wr_data, s_cpuif_wr_biten);
        end else if (cnt_inc_i) begin
            evt_cnt_r <= evt_cnt_r + 32'd1;
        end
    end

endmodule

// File: tb/tb_csr_regblock.sv
// -----------------------------------------------------------------------------
// tb_csr_regblock
//   Scoreboard bench for csr_regblock. Stimulus tasks push the expected
//   response of each CPU access into a queue; a monitor on the falling clock
//   edge pops and compares whenever the DUT raises rd_ack or wr_ack.
//   Side-band outputs (ctrl_o, irq_o) are checked directly by the stimulus.
// -----------------------------------------------------------------------------
module tb_csr_regblock;

    localparam int          AW  = 5;
    localparam logic [31:0] IDV = 32'h5747_0001;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          req;
    logic          req_is_wr;
    logic [AW-1:0] addr;
    logic [31:0]   wr_data;
    logic [31:0]   wr_biten;
    logic          stall_wr;
    logic          stall_rd;
    logic          rd_ack;
    logic          rd_err;
    logic [31:0]   rd_data;
    logic          wr_ack;
    logic          wr_err;
    logic [31:0]   ctrl_o;
    logic [31:0]   status_i;
    logic [31:0]   irq_set_i;
    logic          irq_o;
    logic          cnt_inc_i;

    always #5 clk = ~clk;

    csr_regblock #(.ADDR_WIDTH(AW), .ID_VALUE(IDV)) dut (
        .clk                  (clk),
        .arst_n               (arst_n),
        .s_cpuif_req          (req),
        .s_cpuif_req_is_wr    (req_is_wr),
        .s_cpuif_addr         (addr),
        .s_cpuif_wr_data      (wr_data),
        .s_cpuif_wr_biten     (wr_biten),
        .s_cpuif_req_stall_wr (stall_wr),
        .s_cpuif_req_stall_rd (stall_rd),
        .s_cpuif_rd_ack       (rd_ack),
        .s_cpuif_rd_err       (rd_err),
        .s_cpuif_rd_data      (rd_data),
        .s_cpuif_wr_ack       (wr_ack),
        .s_cpuif_wr_err       (wr_err),
        .ctrl_o               (ctrl_o),
        .status_i             (status_i),
        .irq_set_i            (irq_set_i),
        .irq_o                (irq_o),
        .cnt_inc_i            (cnt_inc_i)
    );

    typedef struct packed {
        logic        is_wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: compare every presented response against the scoreboard head.
    always @(negedge clk) begin
        if (rd_ack || wr_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: rd_ack=%0b wr_ack=%0b with empty scoreboard", rd_ack, wr_ack);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("ack_kind@%02h", mon_e.addr), {30'd0, wr_ack, rd_ack},
                      mon_e.is_wr ? 32'd2 : 32'd1);
                check($sformatf("stall@%02h", mon_e.addr), {30'd0, stall_wr, stall_rd}, 32'd0);
                if (mon_e.is_wr) begin
                    check($sformatf("wr_err@%02h", mon_e.addr), {31'd0, wr_err}, {31'd0, mon_e.err});
                end else begin
                    check($sformatf("rd_data@%02h", mon_e.addr), rd_data, mon_e.data);
                    check($sformatf("rd_err@%02h", mon_e.addr), {31'd0, rd_err}, {31'd0, mon_e.err});
                end
            end
        end
    end

    // Drive one access for a single cycle (entered and left at posedge+1).
    task automatic access(input logic is_wr, input logic [4:0] a, input logic [31:0] wd,
                          input logic [31:0] be, input logic [31:0] exp_d, input logic exp_err);
        exp_t e;
        req       = 1'b1;
        req_is_wr = is_wr;
        addr      = a;
        wr_data   = wd;
        wr_biten  = be;
        e.is_wr   = is_wr;
        e.addr    = a;
        e.data    = exp_d;
        e.err     = exp_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req       = 1'b0;
        req_is_wr = 1'b0;
        wr_data   = 32'h0;
        wr_biten  = 32'h0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp_d, input logic exp_err);
        access(1'b0, a, 32'h0, 32'h0, exp_d, exp_err);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] wd, input logic [31:0] be,
                      input logic exp_err);
        access(1'b1, a, wd, be, 32'h0, exp_err);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst_n    = 1'b0;
        req       = 1'b0;
        req_is_wr = 1'b0;
        addr      = 5'h00;
        wr_data   = 32'h0;
        wr_biten  = 32'h0;
        status_i  = 32'h0;
        irq_set_i = 32'h0;
        cnt_inc_i = 1'b0;
        idle(2);

        // Accesses while held in reset: acked, reads give reset values,
        // writes are dropped.
        rd(5'h00, IDV, 1'b0);
        wr(5'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        rd(5'h04, 32'h0, 1'b0);
        arst_n = 1'b1;
        idle(1);

        // Reset state.
        rd(5'h00, IDV, 1'b0);
        rd(5'h04, 32'h0, 1'b0);
        rd(5'h08, 32'h0, 1'b0);
        rd(5'h10, 32'h0, 1'b0);
        rd(5'h14, 32'h0, 1'b0);
        rd(5'h18, 32'h0, 1'b0);
        check("ctrl_o_reset", ctrl_o, 32'h0);
        check("irq_o_reset", {31'd0, irq_o}, 32'd0);

        // SCRATCH bit-enabled write, CTRL full write.
        wr(5'h04, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
        wr(5'h04, 32'hDEAD_BEEF, 32'h0000_FFFF, 1'b0);
        rd(5'h04, 32'h1234_BEEF, 1'b0);
        check("ctrl_o_before_wr", ctrl_o, 32'h0);
        wr(5'h08, 32'h0000_00A5, 32'hFFFF_FFFF, 1'b0);
        check("ctrl_o_after_wr", ctrl_o, 32'h0000_00A5);
        wr(5'h08, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        rd(5'h08, 32'h0000_00A5, 1'b0);
        check("ctrl_o_biten0", ctrl_o, 32'h0000_00A5);

        // STATUS passthrough, read-only and unmapped accesses.
        status_i = 32'hCAFE_F00D;
        rd(5'h0C, 32'hCAFE_F00D, 1'b0);
        wr(5'h0C, 32'h1111_1111, 32'hFFFF_FFFF, 1'b1);
        rd(5'h0C, 32'hCAFE_F00D, 1'b0);
        rd(5'h1C, 32'h0, 1'b1);
        wr(5'h1C, 32'h2222_2222, 32'hFFFF_FFFF, 1'b1);
        wr(5'h00, 32'h3333_3333, 32'hFFFF_FFFF, 1'b1);
        rd(5'h00, IDV, 1'b0);
        rd(5'h03, IDV, 1'b0);
        status_i = 32'h0;

        // Interrupts.
        wr(5'h14, 32'h0000_0004, 32'hFFFF_FFFF, 1'b0);
        irq_set_i = 32'h5;
        rd(5'h10, 32'h0, 1'b0);
        irq_set_i = 32'h0;
        rd(5'h10, 32'h5, 1'b0);
        check("irq_o_set", {31'd0, irq_o}, 32'd1);
        wr(5'h10, 32'h0000_0004, 32'hFFFF_FFFF, 1'b0);
        rd(5'h10, 32'h1, 1'b0);
        check("irq_o_cleared", {31'd0, irq_o}, 32'd0);
        irq_set_i = 32'h1;
        wr(5'h10, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        irq_set_i = 32'h0;
        rd(5'h10, 32'h1, 1'b0);
        wr(5'h10, 32'h0000_0001, 32'h0000_0000, 1'b0);
        rd(5'h10, 32'h1, 1'b0);
        wr(5'h10, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        rd(5'h10, 32'h0, 1'b0);
        rd(5'h14, 32'h4, 1'b0);

        // Event counter.
        cnt_inc_i = 1'b1;
        idle(3);
        cnt_inc_i = 1'b0;
        rd(5'h18, 32'd3, 1'b0);
        wr(5'h18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        cnt_inc_i = 1'b1;
        idle(1);
        cnt_inc_i = 1'b0;
        rd(5'h18, 32'd0, 1'b0);
        cnt_inc_i = 1'b1;
        wr(5'h18, 32'd5, 32'hFFFF_FFFF, 1'b0);
        rd(5'h18, 32'd5, 1'b0);
        cnt_inc_i = 1'b0;
        rd(5'h18, 32'd6, 1'b0);

        // Asynchronous reset mid-sequence.
        irq_set_i = 32'h4;
        idle(1);
        irq_set_i = 32'h0;
        check("irq_o_pre_reset", {31'd0, irq_o}, 32'd1);
        check("ctrl_o_pre_reset", ctrl_o, 32'h0000_00A5);
        #2;
        arst_n = 1'b0;
        #1;
        check("ctrl_o_async_reset", ctrl_o, 32'h0);
        check("irq_o_async_reset", {31'd0, irq_o}, 32'd0);
        @(posedge clk);
        #1;
        idle(1);
        arst_n = 1'b1;
        idle(1);
        rd(5'h04, 32'h0, 1'b0);
        rd(5'h08, 32'h0, 1'b0);
        rd(5'h10, 32'h0, 1'b0);
        rd(5'h14, 32'h0, 1'b0);
        rd(5'h18, 32'h0, 1'b0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses never seen, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
